alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Transaction-level initiator that drives the team's 16-command combinational ALU port set (a_in, b_in, command_in, oe, d_out). It accepts operation requests on a valid/ready handshake and presents operands, command and output-enable to the ALU. After a programmable settle time it captures the 16-bit result and returns it on a second valid/ready handshake. It keeps divide-by-zero off the ALU and maintains completion and error counters.

Parameters:
SETTLE_CYCLES, 1, cycles alu_oe is held high before d_out is captured; legal range 1..15, 0 is illegal.
COUNT_W, 16, width of op_count and err_count.
DIV_CMD, 4'b0101, command code treated as divide for the zero-divisor check.

Ports:
clk  in  1  single clock; all state changes on rising edge.
rst_n  in  1  asynchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  sequencer can accept a request.
req_cmd  in  4  ALU command code.
req_a  in  8  operand A.
req_b  in  8  operand B.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts the response.
rsp_data  out  16  captured ALU result.
rsp_cmd  out  4  echo of the command for this response.
rsp_err  out  1  1 = divide-by-zero; the operation was not issued.
alu_a  out  8  to ALU a_in.
alu_b  out  8  to ALU b_in.
alu_cmd  out  4  to ALU command_in.
alu_oe  out  1  to ALU oe.
alu_d  in  16  from ALU d_out.
op_count  out  COUNT_W  completed response handshakes; wraps.
err_count  out  COUNT_W  divide-by-zero responses; saturates at all-ones.

Behaviour:
- Reset (rst_n low, takes effect immediately): state = IDLE. All outputs are 0 except req_ready = 1. This includes alu_oe = 0, rsp_valid = 0, both counters = 0 and alu_a/alu_b/alu_cmd = 0.
- States: IDLE, DRIVE, RESP. req_ready = 1 only in IDLE, decoded from state.
- IDLE to DRIVE: on an edge with req_valid & req_ready, provided the request is not a divide by zero.
  - req_a, req_b and req_cmd are registered into alu_a, alu_b, alu_cmd and rsp_cmd.
  - alu_oe is set to 1.
  - The settle counter is loaded with SETTLE_CYCLES-1.
- IDLE to RESP (divide by zero): on accept with req_cmd == DIV_CMD and req_b == 0.
  - alu_a, alu_b, alu_cmd and alu_oe are left unchanged (alu_oe stays 0).
  - rsp_data = 16'hFFFF, rsp_err = 1, rsp_cmd = req_cmd.
  - rsp_valid rises at the accepting edge.
- DRIVE: alu_oe = 1 and the ALU inputs are stable.
  - If the counter is nonzero, it decrements by 1.
  - If the counter is zero, rsp_data is loaded from alu_d, rsp_err = 0, alu_oe = 0, rsp_valid = 1, and the state moves to RESP.
  - Latency: rsp_valid rises at the SETTLE_CYCLES-th rising edge after the accepting edge.
- RESP: rsp_valid = 1. rsp_data, rsp_cmd and rsp_err are held stable while rsp_ready = 0.
  - On rsp_valid & rsp_ready: rsp_valid = 0, state returns to IDLE, op_count increments.
  - On the same edge, err_count increments if rsp_err = 1, unless it is already all-ones.
- Throughput: one operation in flight, no pipelining. The earliest next accept is the cycle after the response handshake.
- alu_a, alu_b and alu_cmd hold their last values outside DRIVE. alu_oe is 1 only in DRIVE.
- op_count wraps from all-ones to 0. err_count saturates at all-ones.
- req_* inputs are ignored when req_ready = 0. rsp_ready is ignored when rsp_valid = 0.
- The sequencer never inspects or interprets result values. It captures alu_d exactly; any high-Z bits present at capture are not its responsibility.
- Reset mid-operation (DRIVE or RESP):
  - alu_oe and rsp_valid drop immediately.
  - The pending response is discarded and the counters clear.
  - After rst_n rises, the next accepted request behaves as it would after the first reset.

Test Plan:
- Reset release: rsp_valid = 0, alu_oe = 0, req_ready = 1, op_count = 0, err_count = 0. Assert rst_n during DRIVE: alu_oe drops with no clock edge.
- With SETTLE_CYCLES = 1 and the ALU connected, send ADD a = 8'hFF, b = 8'h01: alu_oe is high for exactly 1 cycle, rsp_valid rises 1 edge after accept, rsp_data = 16'h0100, rsp_err = 0, op_count = 1.
- MUL a = 8'hFF, b = 8'hFF gives rsp_data = 16'hFE01. SUB a = 3, b = 5 gives 16'hFFFE. DIV a = 100, b = 7 gives 16'h000E. Issue back-to-back with rsp_ready tied high: each accept occurs the cycle after the previous handshake, and op_count = 3.
- DIV a = 8'h10, b = 0: alu_oe never rises, rsp_valid rises at the accepting edge, rsp_data = 16'hFFFF, rsp_err = 1, rsp_cmd = 4'b0101, err_count = 1.
- Backpressure on XOR 8'hAA ^ 8'h0F: hold rsp_ready = 0 for 5 cycles. rsp_data = 16'h00A5 stays stable and req_ready stays 0 even with a new req_valid. The new request is accepted the cycle after the handshake.
- Parameter and counter boundaries: with SETTLE_CYCLES = 4, alu_oe is high for exactly 4 cycles and rsp_valid rises at the 4th edge after accept. With COUNT_W = 4, 16 ops wrap op_count to 0, and 17 div-by-zero ops leave err_count = 4'hF.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: one-at-a-time initiator for the 16-command combinational ALU.
// Takes a request on a valid/ready handshake, holds operands on the ALU with
// oe high for SETTLE_CYCLES cycles, captures d_out and returns it on a second
// valid/ready handshake. Divide-by-zero is answered locally and never issued.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | req_ready high, waiting for a request
// ST_DRIVE | alu_oe high, operands stable, settle counter running down
// ST_RESP  | rsp_valid high, response held until rsp_ready
module alu_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned COUNT_W       = 16,
    parameter logic [3:0]  DIV_CMD       = 4'b0101
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [3:0]         req_cmd,
    input  logic [7:0]         req_a,
    input  logic [7:0]         req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [15:0]        rsp_data,
    output logic [3:0]         rsp_cmd,
    output logic               rsp_err,
    output logic [7:0]         alu_a,
    output logic [7:0]         alu_b,
    output logic [3:0]         alu_cmd,
    output logic               alu_oe,
    input  logic [15:0]        alu_d,
    output logic [COUNT_W-1:0] op_count,
    output logic [COUNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Counter is loaded with SETTLE_CYCLES-1 so the capture edge lands on
    // the SETTLE_CYCLES-th edge after the accept.
    localparam logic [3:0]         SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] CNT_ONE     = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] CNT_MAX     = '1;

    // A zero settle time would capture d_out on the accepting edge itself.
    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("alu_sequencer: SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

    state_t             r_state;
    logic [3:0]         r_settle;
    logic [7:0]         r_alu_a;
    logic [7:0]         r_alu_b;
    logic [3:0]         r_alu_cmd;
    logic               r_alu_oe;
    logic               r_rsp_valid;
    logic [15:0]        r_rsp_data;
    logic [3:0]         r_rsp_cmd;
    logic               r_rsp_err;
    logic [COUNT_W-1:0] r_op_count;
    logic [COUNT_W-1:0] r_err_count;

    logic w_accept;
    logic w_div_zero;
    logic w_rsp_done;

    assign w_accept   = req_valid && (r_state == ST_IDLE);
    assign w_div_zero = (req_cmd == DIV_CMD) && (req_b == 8'h00);
    assign w_rsp_done = r_rsp_valid && rsp_ready;

    // Sequencer FSM with all ALU-side and response-side outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_settle    <= 4'd0;
            r_alu_a     <= 8'd0;
            r_alu_b     <= 8'd0;
            r_alu_cmd   <= 4'd0;
            r_alu_oe    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 16'd0;
            r_rsp_cmd   <= 4'd0;
            r_rsp_err   <= 1'b0;
            r_op_count  <= '0;
            r_err_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_rsp_cmd <= req_cmd;
                        if (w_div_zero) begin
                            // Answer locally; ALU-side registers keep old values.
                            r_rsp_data  <= 16'hFFFF;
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end else begin
                            r_alu_a   <= req_a;
                            r_alu_b   <= req_b;
                            r_alu_cmd <= req_cmd;
                            r_alu_oe  <= 1'b1;
                            r_settle  <= SETTLE_LOAD;
                            r_state   <= ST_DRIVE;
                        end
                    end
                end
                ST_DRIVE: begin
                    if (r_settle != 4'd0) begin
                        r_settle <= r_settle - 4'd1;
                    end else begin
                        r_rsp_data  <= alu_d;
                        r_rsp_err   <= 1'b0;
                        r_alu_oe    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_rsp_done) begin
                        r_rsp_valid <= 1'b0;
                        r_op_count  <= r_op_count + CNT_ONE;
                        if (r_rsp_err && (r_err_count != CNT_MAX)) begin
                            r_err_count <= r_err_count + CNT_ONE;
                        end
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_alu_oe    <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_cmd   = r_rsp_cmd;
    assign rsp_err   = r_rsp_err;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_cmd   = r_alu_cmd;
    assign alu_oe    = r_alu_oe;
    assign op_count  = r_op_count;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: two instances (SETTLE 1 / 16-bit counters and
// SETTLE 4 / 4-bit counters), each driving a behavioural ALU stand-in.
module tb_alu_sequencer;

    localparam logic [3:0] C_ADD = 4'd0;
    localparam logic [3:0] C_SUB = 4'd1;
    localparam logic [3:0] C_MUL = 4'd4;
    localparam logic [3:0] C_DIV = 4'd5;
    localparam logic [3:0] C_XOR = 4'd6;

    int n_checks = 0;
    int n_fails  = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // Behavioural ALU: the environment the sequencer drives.
    function automatic logic [15:0] alu_f(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] aa, bb;
        aa = {8'h00, a};
        bb = {8'h00, b};
        case (c)
            4'd0:    return aa + bb;
            4'd1:    return aa - bb;
            4'd2:    return aa & bb;
            4'd3:    return aa | bb;
            4'd4:    return aa * bb;
            4'd5:    return (b == 8'h00) ? 16'hFFFF : aa / bb;
            4'd6:    return aa ^ bb;
            default: return {a, b};
        endcase
    endfunction

    // Expected response from the sequencer's rules: div-by-zero answered locally.
    function automatic logic [15:0] exp_data(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        if (c == C_DIV && b == 8'h00) return 16'hFFFF;
        return alu_f(c, a, b);
    endfunction

    // ---------------- instance 1: SETTLE_CYCLES = 1, COUNT_W = 16
    logic        req_valid = 1'b0, rsp_ready = 1'b0;
    logic [3:0]  req_cmd = '0;
    logic [7:0]  req_a = '0, req_b = '0;
    logic        req_ready, rsp_valid, rsp_err, alu_oe;
    logic [15:0] rsp_data, alu_d, op_count, err_count;
    logic [3:0]  rsp_cmd, alu_cmd;
    logic [7:0]  alu_a, alu_b;

    assign alu_d = alu_oe ? alu_f(alu_cmd, alu_a, alu_b) : 16'hDEAD;

    alu_sequencer #(.SETTLE_CYCLES(1), .COUNT_W(16), .DIV_CMD(4'b0101)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_cmd(rsp_cmd), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_oe(alu_oe),
        .alu_d(alu_d), .op_count(op_count), .err_count(err_count)
    );

    // ---------------- instance 4: SETTLE_CYCLES = 4, COUNT_W = 4
    logic        req_valid_4 = 1'b0, rsp_ready_4 = 1'b0;
    logic [3:0]  req_cmd_4 = '0;
    logic [7:0]  req_a_4 = '0, req_b_4 = '0;
    logic        req_ready_4, rsp_valid_4, rsp_err_4, alu_oe_4;
    logic [15:0] rsp_data_4, alu_d_4;
    logic [3:0]  rsp_cmd_4, alu_cmd_4, op_count_4, err_count_4;
    logic [7:0]  alu_a_4, alu_b_4;

    assign alu_d_4 = alu_oe_4 ? alu_f(alu_cmd_4, alu_a_4, alu_b_4) : 16'hDEAD;

    alu_sequencer #(.SETTLE_CYCLES(4), .COUNT_W(4), .DIV_CMD(4'b0101)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_4), .req_ready(req_ready_4), .req_cmd(req_cmd_4),
        .req_a(req_a_4), .req_b(req_b_4),
        .rsp_valid(rsp_valid_4), .rsp_ready(rsp_ready_4), .rsp_data(rsp_data_4),
        .rsp_cmd(rsp_cmd_4), .rsp_err(rsp_err_4),
        .alu_a(alu_a_4), .alu_b(alu_b_4), .alu_cmd(alu_cmd_4), .alu_oe(alu_oe_4),
        .alu_d(alu_d_4), .op_count(op_count_4), .err_count(err_count_4)
    );

    // ---------------- stimulus tasks (all keep the "1 after posedge" phase)
    task automatic do_reset();
        req_valid = 0; rsp_ready = 0; req_valid_4 = 0; rsp_ready_4 = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic send1(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b, output int waited);
        int n = 0;
        req_cmd = c; req_a = a; req_b = b; req_valid = 1;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        waited = n;
        n_checks++;
        if (req_ready !== 1'b1) begin n_fails++; $display("FAIL send1_timeout: req_ready=%b after %0d cycles, required 1", req_ready, n); end
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic wait_rsp1(output int lat, output int oe_cnt);
        lat = 0; oe_cnt = 0;
        while (!rsp_valid && lat < 40) begin
            if (alu_oe) oe_cnt++;
            @(posedge clk); #1; lat++;
        end
        n_checks++;
        if (rsp_valid !== 1'b1) begin n_fails++; $display("FAIL wait_rsp1_timeout: rsp_valid=%b, required 1", rsp_valid); end
    endtask

    task automatic hs1(input int hold);
        rsp_ready = 0;
        repeat (hold) begin @(posedge clk); #1; end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
    endtask

    task automatic send4(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        req_cmd_4 = c; req_a_4 = a; req_b_4 = b; req_valid_4 = 1;
        while (!req_ready_4 && n < 50) begin @(posedge clk); #1; n++; end
        n_checks++;
        if (req_ready_4 !== 1'b1) begin n_fails++; $display("FAIL send4_timeout: req_ready=%b, required 1", req_ready_4); end
        @(posedge clk); #1;
        req_valid_4 = 0;
    endtask

    task automatic wait_rsp4(output int lat, output int oe_cnt);
        lat = 0; oe_cnt = 0;
        while (!rsp_valid_4 && lat < 40) begin
            if (alu_oe_4) oe_cnt++;
            @(posedge clk); #1; lat++;
        end
        n_checks++;
        if (rsp_valid_4 !== 1'b1) begin n_fails++; $display("FAIL wait_rsp4_timeout: rsp_valid=%b, required 1", rsp_valid_4); end
    endtask

    task automatic hs4();
        rsp_ready_4 = 1;
        @(posedge clk); #1;
        rsp_ready_4 = 0;
    endtask

    // ---------------- tests
    task automatic test_reset();
        do_reset();
        n_checks += 9;
        if (rsp_valid !== 1'b0)  begin n_fails++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
        if (alu_oe !== 1'b0)     begin n_fails++; $display("FAIL reset_alu_oe: got %b required 0", alu_oe); end
        if (req_ready !== 1'b1)  begin n_fails++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
        if (op_count !== 16'd0)  begin n_fails++; $display("FAIL reset_op_count: got %h required 0", op_count); end
        if (err_count !== 16'd0) begin n_fails++; $display("FAIL reset_err_count: got %h required 0", err_count); end
        if (rsp_data !== 16'd0)  begin n_fails++; $display("FAIL reset_rsp_data: got %h required 0", rsp_data); end
        if ({alu_a, alu_b, alu_cmd} !== 20'd0) begin n_fails++; $display("FAIL reset_alu_bus: got %h required 0", {alu_a, alu_b, alu_cmd}); end
        if (req_ready_4 !== 1'b1) begin n_fails++; $display("FAIL reset_req_ready4: got %b required 1", req_ready_4); end
        if ({rsp_valid_4, alu_oe_4, op_count_4, err_count_4} !== 10'd0) begin n_fails++; $display("FAIL reset_dut4_state: got %h required 0", {rsp_valid_4, alu_oe_4, op_count_4, err_count_4}); end
    endtask

    task automatic test_add();
        int w, lat, oe;
        send1(C_ADD, 8'hFF, 8'h01, w);
        wait_rsp1(lat, oe);
        n_checks += 6;
        if (oe !== 1)              begin n_fails++; $display("FAIL add_oe_cycles: got %0d required 1", oe); end
        if (lat !== 1)             begin n_fails++; $display("FAIL add_latency: got %0d required 1", lat); end
        if (rsp_data !== 16'h0100) begin n_fails++; $display("FAIL add_data: got %h required 0100", rsp_data); end
        if (rsp_err !== 1'b0)      begin n_fails++; $display("FAIL add_err: got %b required 0", rsp_err); end
        if (alu_oe !== 1'b0)       begin n_fails++; $display("FAIL add_oe_after: got %b required 0", alu_oe); end
        if (rsp_cmd !== C_ADD)     begin n_fails++; $display("FAIL add_cmd: got %h required %h", rsp_cmd, C_ADD); end
        hs1(0);
        n_checks++;
        if (op_count !== 16'd1)    begin n_fails++; $display("FAIL add_op_count: got %0d required 1", op_count); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  cs [3] = '{C_MUL, C_SUB, C_DIV};
        logic [7:0]  as [3] = '{8'hFF, 8'd3, 8'd100};
        logic [7:0]  bs [3] = '{8'hFF, 8'd5, 8'd7};
        logic [15:0] es [3] = '{16'hFE01, 16'hFFFE, 16'h000E};
        int w, lat, oe;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send1(cs[i], as[i], bs[i], w);
            wait_rsp1(lat, oe);
            n_checks += 3;
            if (w !== 0)             begin n_fails++; $display("FAIL b2b_accept_wait[%0d]: got %0d required 0", i, w); end
            if (lat !== 1)           begin n_fails++; $display("FAIL b2b_latency[%0d]: got %0d required 1", i, lat); end
            if (rsp_data !== es[i])  begin n_fails++; $display("FAIL b2b_data[%0d]: got %h required %h", i, rsp_data, es[i]); end
            hs1(0);
            n_checks++;
            if (req_ready !== 1'b1)  begin n_fails++; $display("FAIL b2b_ready_after_hs[%0d]: got %b required 1", i, req_ready); end
        end
        n_checks++;
        if (op_count !== 16'd3)      begin n_fails++; $display("FAIL b2b_op_count: got %0d required 3", op_count); end
    endtask

    task automatic test_div_zero();
        int w, lat, oe;
        logic [15:0] ops_before;
        ops_before = 16'd3;
        send1(C_DIV, 8'h10, 8'h00, w);
        wait_rsp1(lat, oe);
        n_checks += 6;
        if (lat !== 0)             begin n_fails++; $display("FAIL div0_latency: got %0d required 0", lat); end
        if (alu_oe !== 1'b0)       begin n_fails++; $display("FAIL div0_alu_oe: got %b required 0", alu_oe); end
        if (rsp_data !== 16'hFFFF) begin n_fails++; $display("FAIL div0_data: got %h required FFFF", rsp_data); end
        if (rsp_err !== 1'b1)      begin n_fails++; $display("FAIL div0_err: got %b required 1", rsp_err); end
        if (rsp_cmd !== 4'b0101)   begin n_fails++; $display("FAIL div0_cmd: got %b required 0101", rsp_cmd); end
        if (alu_b !== 8'd7)        begin n_fails++; $display("FAIL div0_alu_b_held: got %h required 07", alu_b); end
        hs1(1);
        n_checks += 3;
        if (alu_oe !== 1'b0)       begin n_fails++; $display("FAIL div0_alu_oe_after: got %b required 0", alu_oe); end
        if (err_count !== 16'd1)   begin n_fails++; $display("FAIL div0_err_count: got %0d required 1", err_count); end
        if (op_count !== ops_before + 16'd1) begin n_fails++; $display("FAIL div0_op_count: got %0d required %0d", op_count, ops_before + 16'd1); end
    endtask

    task automatic test_backpressure();
        int w, lat, oe;
        send1(C_XOR, 8'hAA, 8'h0F, w);
        wait_rsp1(lat, oe);
        n_checks++;
        if (rsp_data !== 16'h00A5) begin n_fails++; $display("FAIL bp_data: got %h required 00A5", rsp_data); end
        req_cmd = C_ADD; req_a = 8'd1; req_b = 8'd2; req_valid = 1; rsp_ready = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks += 4;
            if (rsp_data !== 16'h00A5) begin n_fails++; $display("FAIL bp_hold_data[%0d]: got %h required 00A5", i, rsp_data); end
            if (rsp_valid !== 1'b1)    begin n_fails++; $display("FAIL bp_hold_valid[%0d]: got %b required 1", i, rsp_valid); end
            if (req_ready !== 1'b0)    begin n_fails++; $display("FAIL bp_hold_ready[%0d]: got %b required 0", i, req_ready); end
            if (alu_a !== 8'hAA)       begin n_fails++; $display("FAIL bp_hold_alu_a[%0d]: got %h required AA", i, alu_a); end
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        n_checks += 2;
        if (req_ready !== 1'b1) begin n_fails++; $display("FAIL bp_ready_after_hs: got %b required 1", req_ready); end
        if (rsp_valid !== 1'b0) begin n_fails++; $display("FAIL bp_valid_after_hs: got %b required 0", rsp_valid); end
        send1(C_ADD, 8'd1, 8'd2, w);
        wait_rsp1(lat, oe);
        n_checks += 2;
        if (w !== 0)               begin n_fails++; $display("FAIL bp_next_accept_wait: got %0d required 0", w); end
        if (rsp_data !== 16'h0003) begin n_fails++; $display("FAIL bp_next_data: got %h required 0003", rsp_data); end
        hs1(0);
    endtask

    task automatic test_reset_mid_drive();
        int w, lat, oe;
        send1(C_ADD, 8'h12, 8'h34, w);
        n_checks++;
        if (alu_oe !== 1'b1) begin n_fails++; $display("FAIL rst_mid_oe_before: got %b required 1", alu_oe); end
        #2 rst_n = 0;
        #1;
        n_checks += 4;
        if (alu_oe !== 1'b0)     begin n_fails++; $display("FAIL rst_mid_oe_async: got %b required 0", alu_oe); end
        if (rsp_valid !== 1'b0)  begin n_fails++; $display("FAIL rst_mid_valid: got %b required 0", rsp_valid); end
        if (op_count !== 16'd0)  begin n_fails++; $display("FAIL rst_mid_op_count: got %0d required 0", op_count); end
        if (err_count !== 16'd0) begin n_fails++; $display("FAIL rst_mid_err_count: got %0d required 0", err_count); end
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
        send1(C_SUB, 8'h40, 8'h01, w);
        wait_rsp1(lat, oe);
        n_checks += 3;
        if (lat !== 1)             begin n_fails++; $display("FAIL rst_mid_after_latency: got %0d required 1", lat); end
        if (rsp_data !== 16'h003F) begin n_fails++; $display("FAIL rst_mid_after_data: got %h required 003F", rsp_data); end
        if (w !== 0)               begin n_fails++; $display("FAIL rst_mid_after_wait: got %0d required 0", w); end
        hs1(0);
        n_checks++;
        if (op_count !== 16'd1)    begin n_fails++; $display("FAIL rst_mid_after_op_count: got %0d required 1", op_count); end
    endtask

    task automatic test_random();
        int w, lat, oe, hold;
        int exp_ops = 0, exp_errs = 0;
        logic [3:0] c; logic [7:0] a, b;
        logic [15:0] ed; logic ee;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            c = 4'($urandom_range(0, 7));
            a = 8'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            hold = $urandom_range(0, 3);
            ed = exp_data(c, a, b);
            ee = (c == C_DIV) && (b == 8'h00);
            send1(c, a, b, w);
            wait_rsp1(lat, oe);
            n_checks += 5;
            if (rsp_data !== ed)          begin n_fails++; $display("FAIL rnd_data[%0d]: cmd=%h a=%h b=%h got %h required %h", i, c, a, b, rsp_data, ed); end
            if (rsp_err !== ee)           begin n_fails++; $display("FAIL rnd_err[%0d]: got %b required %b", i, rsp_err, ee); end
            if (rsp_cmd !== c)            begin n_fails++; $display("FAIL rnd_cmd[%0d]: got %h required %h", i, rsp_cmd, c); end
            if (lat !== (ee ? 0 : 1))     begin n_fails++; $display("FAIL rnd_latency[%0d]: got %0d required %0d", i, lat, ee ? 0 : 1); end
            if (oe !== (ee ? 0 : 1))      begin n_fails++; $display("FAIL rnd_oe_cycles[%0d]: got %0d required %0d", i, oe, ee ? 0 : 1); end
            hs1(hold);
            exp_ops = (exp_ops + 1) % 65536;
            if (ee && exp_errs < 65535) exp_errs++;
        end
        n_checks += 2;
        if (op_count !== 16'(exp_ops))   begin n_fails++; $display("FAIL rnd_op_count: got %0d required %0d", op_count, exp_ops); end
        if (err_count !== 16'(exp_errs)) begin n_fails++; $display("FAIL rnd_err_count: got %0d required %0d", err_count, exp_errs); end
    endtask

    task automatic test_settle4();
        int lat, oe;
        send4(C_MUL, 8'd12, 8'd11);
        wait_rsp4(lat, oe);
        n_checks += 4;
        if (oe !== 4)                begin n_fails++; $display("FAIL s4_oe_cycles: got %0d required 4", oe); end
        if (lat !== 4)               begin n_fails++; $display("FAIL s4_latency: got %0d required 4", lat); end
        if (rsp_data_4 !== 16'd132)  begin n_fails++; $display("FAIL s4_data: got %h required 0084", rsp_data_4); end
        if (alu_oe_4 !== 1'b0)       begin n_fails++; $display("FAIL s4_oe_after: got %b required 0", alu_oe_4); end
        hs4();
    endtask

    task automatic test_count_wrap();
        int lat, oe;
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            send4(4'($urandom_range(0, 4)), 8'($urandom), 8'($urandom_range(1, 255)));
            wait_rsp4(lat, oe);
            hs4();
            if (i == 15) begin
                n_checks++;
                if (op_count_4 !== 4'hF) begin n_fails++; $display("FAIL wrap_op_count_15: got %h required F", op_count_4); end
            end
        end
        n_checks++;
        if (op_count_4 !== 4'h0) begin n_fails++; $display("FAIL wrap_op_count_16: got %h required 0", op_count_4); end
        for (int i = 1; i <= 17; i++) begin
            send4(C_DIV, 8'($urandom), 8'h00);
            wait_rsp4(lat, oe);
            hs4();
            if (i == 14 || i >= 15) begin
                n_checks++;
                if (err_count_4 !== 4'((i > 15) ? 15 : i)) begin n_fails++; $display("FAIL sat_err_count_%0d: got %h required %h", i, err_count_4, 4'((i > 15) ? 15 : i)); end
            end
        end
        n_checks++;
        if (op_count_4 !== 4'h1) begin n_fails++; $display("FAIL wrap_op_count_33: got %h required 1", op_count_4); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_div_zero();
        test_backpressure();
        test_reset_mid_drive();
        test_random();
        test_settle4();
        test_count_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
        $fatal(1, "timeout");
    end

endmodule
